// File: rtl/byte_packer_32.sv
// byte_packer_32: packs valid-qualified bytes MSB-first into 32-bit words behind a valid/ready slot, with zero-padded flush.
// Optional PACKER_WORD_COUNT_EN adds a 16-bit wrapping count of drained words.
module byte_packer_32 (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    input  logic        flush,
    input  logic        ready_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic [1:0]  byte_cnt
`ifdef PACKER_WORD_COUNT_EN
    ,
    output logic [15:0] word_count
`endif
);
    logic [23:0] acc, acc_nx;
    logic [1:0]  cnt_nx;
    logic        flush_pend, slot_free, accept, complete, flush_req, emit_flush, load;
    logic [4:0]  sh;
    logic [31:0] pad;
    always_comb begin
        slot_free  = !valid_out || ready_in;
        ready_out  = !flush_pend && ((byte_cnt != 2'd3) || slot_free);
        accept     = valid_in && ready_out;
        complete   = accept && (byte_cnt == 2'd3);
        acc_nx     = accept ? {acc[15:0], data_in} : acc;
        cnt_nx     = accept ? byte_cnt + 2'd1 : byte_cnt;
        // a completing byte wraps cnt_nx to 0, which also consumes a same-cycle flush
        flush_req  = (flush || flush_pend) && (cnt_nx != 2'd0);
        emit_flush = flush_req && slot_free;
        load       = complete || emit_flush;
        sh         = {2'd3 - cnt_nx, 3'b000};
        pad        = {acc_nx, 8'h00} << sh;
    end
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            byte_cnt   <= '0;
            flush_pend <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
        end else begin
            acc        <= acc_nx;
            byte_cnt   <= emit_flush ? 2'd0 : cnt_nx;
            flush_pend <= flush_req && !slot_free;
            valid_out  <= load || (valid_out && !ready_in);
            if (load)
                data_out <= complete ? {acc, data_in} : pad;
        end
    end
`ifdef PACKER_WORD_COUNT_EN
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset)
            word_count <= '0;
        else if (valid_out && ready_in)
            word_count <= word_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_byte_packer_32.sv
// tb_byte_packer_32: directed self-checking bench for byte_packer_32.
module tb_byte_packer_32;
    logic        clk_2f = 1'b0;
    logic        reset, valid_in, flush, ready_in;
    logic [7:0]  data_in;
    logic        ready_out, valid_out;
    logic [31:0] data_out;
    logic [1:0]  byte_cnt;
`ifdef PACKER_WORD_COUNT_EN
    logic [15:0] word_count;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk_2f = ~clk_2f;

    byte_packer_32 dut (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .flush(flush), .ready_in(ready_in), .ready_out(ready_out),
        .valid_out(valid_out), .data_out(data_out), .byte_cnt(byte_cnt)
`ifdef PACKER_WORD_COUNT_EN
        , .word_count(word_count)
`endif
    );

    task automatic tick;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        valid_in = 1'b1;
        data_in  = b;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; valid_in = 1'b0; data_in = 8'h00; flush = 1'b0; ready_in = 1'b0;
        tick(); reset = 1'b0; tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h want=0", valid_out); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%08h want=00000000", data_out); end
        checks++; if (byte_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", byte_cnt); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h want=1", ready_out); end
        for (int i = 1; i <= 6; i++) feed(8'(i));
        checks++; if (valid_out !== 1'b1 || byte_cnt !== 2'd2) begin failures++; $display("FAIL reset_setup valid=%0h cnt=%0d want valid=1 cnt=2", valid_out, byte_cnt); end
        #2 reset = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0 || data_out !== 32'h0 || byte_cnt !== 2'd0) begin failures++; $display("FAIL reset_async valid=%0h data=%08h cnt=%0d want 0/00000000/0", valid_out, data_out, byte_cnt); end
        tick(); reset = 1'b0; ready_in = 1'b1;
        feed(8'hAA); feed(8'hBB); feed(8'hCC); feed(8'hDD);
        checks++; if (valid_out !== 1'b1 || data_out !== 32'hAABBCCDD) begin failures++; $display("FAIL reset_after valid=%0h data=%08h want 1/AABBCCDD", valid_out, data_out); end
        tick();
    endtask

    task automatic test_stream;
        ready_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            valid_in = 1'b1; data_in = 8'(i);
            tick();
            if (i == 4) begin
                checks++; if (valid_out !== 1'b1 || data_out !== 32'h01020304) begin failures++; $display("FAIL stream_w0 valid=%0h data=%08h want 1/01020304", valid_out, data_out); end
            end else if (i == 8) begin
                checks++; if (valid_out !== 1'b1 || data_out !== 32'h05060708) begin failures++; $display("FAIL stream_w1 valid=%0h data=%08h want 1/05060708", valid_out, data_out); end
            end else begin
                checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL stream_gap%0d valid=%0h want 0", i, valid_out); end
            end
        end
        valid_in = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL stream_end valid=%0h want 0", valid_out); end
    endtask

    task automatic test_backpressure;
        ready_in = 1'b1;
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        ready_in = 1'b0;
        feed(8'h11); feed(8'h12); feed(8'h13);
        valid_in = 1'b1; data_in = 8'h14;
        #1;
        checks++; if (ready_out !== 1'b0 || byte_cnt !== 2'd3) begin failures++; $display("FAIL bp_stall ready=%0h cnt=%0d want 0/3", ready_out, byte_cnt); end
        tick();
        checks++; if (ready_out !== 1'b0 || byte_cnt !== 2'd3 || valid_out !== 1'b1 || data_out !== 32'h01020304) begin failures++; $display("FAIL bp_hold ready=%0h cnt=%0d valid=%0h data=%08h want 0/3/1/01020304", ready_out, byte_cnt, valid_out, data_out); end
        ready_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL bp_release ready=%0h want 1", ready_out); end
        tick();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h11121314 || byte_cnt !== 2'd0) begin failures++; $display("FAIL bp_word valid=%0h data=%08h cnt=%0d want 1/11121314/0", valid_out, data_out, byte_cnt); end
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_drain valid=%0h want 0", valid_out); end
    endtask

    task automatic test_flush;
        ready_in = 1'b1;
        feed(8'hA1); feed(8'hA2);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 32'hA1A20000 || byte_cnt !== 2'd0) begin failures++; $display("FAIL flush_two valid=%0h data=%08h cnt=%0d want 1/A1A20000/0", valid_out, data_out, byte_cnt); end
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (valid_out !== 1'b0 || data_out !== 32'hA1A20000 || byte_cnt !== 2'd0) begin failures++; $display("FAIL flush_empty valid=%0h data=%08h cnt=%0d want 0/A1A20000/0", valid_out, data_out, byte_cnt); end
        feed(8'h01); feed(8'h02); feed(8'h03);
        flush = 1'b1; feed(8'h04); flush = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h01020304 || byte_cnt !== 2'd0) begin failures++; $display("FAIL flush_full valid=%0h data=%08h cnt=%0d want 1/01020304/0", valid_out, data_out, byte_cnt); end
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_noextra valid=%0h want 0", valid_out); end
        flush = 1'b1; feed(8'h55); flush = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h55000000) begin failures++; $display("FAIL flush_one valid=%0h data=%08h want 1/55000000", valid_out, data_out); end
        feed(8'hB1); feed(8'hB2); feed(8'hB3);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 32'hB1B2B300) begin failures++; $display("FAIL flush_three valid=%0h data=%08h want 1/B1B2B300", valid_out, data_out); end
        tick();
    endtask

    task automatic test_pending_flush;
        ready_in = 1'b1;
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        ready_in = 1'b0;
        feed(8'h77);
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (ready_out !== 1'b0 || byte_cnt !== 2'd1 || valid_out !== 1'b1 || data_out !== 32'h01020304) begin failures++; $display("FAIL pend_latch ready=%0h cnt=%0d valid=%0h data=%08h want 0/1/1/01020304", ready_out, byte_cnt, valid_out, data_out); end
        feed(8'h88);
        checks++; if (byte_cnt !== 2'd1 || ready_out !== 1'b0) begin failures++; $display("FAIL pend_block cnt=%0d ready=%0h want 1/0", byte_cnt, ready_out); end
        ready_in = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL pend_ready ready=%0h want 0", ready_out); end
        tick();
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h77000000 || byte_cnt !== 2'd0 || ready_out !== 1'b1) begin failures++; $display("FAIL pend_word valid=%0h data=%08h cnt=%0d ready=%0h want 1/77000000/0/1", valid_out, data_out, byte_cnt, ready_out); end
        tick();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL pend_drain valid=%0h want 0", valid_out); end
    endtask

`ifdef PACKER_WORD_COUNT_EN
    task automatic test_word_count;
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (word_count !== 16'h0) begin failures++; $display("FAIL wc_reset got=%04h want=0000", word_count); end
        ready_in = 1'b1; valid_in = 1'b1; flush = 1'b1; data_in = 8'h5A;
        tick();
        for (int i = 0; i < 65535; i++) tick();
        valid_in = 1'b0; flush = 1'b0;
        checks++; if (word_count !== 16'hFFFF) begin failures++; $display("FAIL wc_full got=%04h want=FFFF", word_count); end
        tick();
        checks++; if (word_count !== 16'h0000) begin failures++; $display("FAIL wc_wrap got=%04h want=0000", word_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_pending_flush();
`ifdef PACKER_WORD_COUNT_EN
        test_word_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
